// File: rtl/hdlverifier_capture_trigger_config.sv
// Host-loaded trigger configuration: receives a 12-byte framed packet, verifies it,
// and commits the 75-bit trigger word once no capture is running.
module hdlverifier_capture_trigger_config #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [7:0]  cfg_data,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic        capture_busy,
    output logic [74:0] trigger_setting,
    output logic        setting_update,
    output logic        cfg_error
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [7:0]      HEADER   = 8'hA5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        CKSUM   = 2'd2,
        PENDING = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [79:0]      shadow_q, shadow_d;
    logic [3:0]       idx_q, idx_d;
    logic [7:0]       xor_q, xor_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [74:0]      setting_d;
    logic             update_d;
    logic             error_d;
    logic             accept;
    logic             tmo_hit;

    assign cfg_ready = clk_enable & ~reset & (state_q != PENDING);
    assign accept    = cfg_valid & cfg_ready;
    // The idle edge that would take the counter to TIMEOUT is the abort edge.
    assign tmo_hit   = (tmo_q == TMO_LAST);

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        idx_d     = idx_q;
        xor_d     = xor_q;
        tmo_d     = tmo_q;
        setting_d = trigger_setting;
        update_d  = 1'b0;
        error_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept && cfg_data == HEADER) begin
                    state_d  = LOAD;
                    shadow_d = '0;
                    idx_d    = '0;
                    xor_d    = '0;
                    tmo_d    = '0;
                end
            end

            LOAD: begin
                if (accept) begin
                    for (int k = 0; k < 10; k++) begin
                        if (idx_q == 4'(k)) begin
                            shadow_d[8*k +: 8] = cfg_data;
                        end
                    end
                    xor_d = xor_q ^ cfg_data;
                    idx_d = idx_q + 4'd1;
                    tmo_d = '0;
                    if (idx_q == 4'd9) begin
                        state_d = CKSUM;
                    end
                end else if (tmo_hit) begin
                    state_d  = IDLE;
                    error_d  = 1'b1;
                    shadow_d = '0;
                    idx_d    = '0;
                    xor_d    = '0;
                    tmo_d    = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            CKSUM: begin
                if (accept) begin
                    tmo_d = '0;
                    // Bits above the 75-bit trigger word are reserved and must be zero.
                    if (cfg_data == xor_q && shadow_q[79:75] == 5'd0) begin
                        state_d = PENDING;
                    end else begin
                        state_d  = IDLE;
                        error_d  = 1'b1;
                        shadow_d = '0;
                        idx_d    = '0;
                        xor_d    = '0;
                    end
                end else if (tmo_hit) begin
                    state_d  = IDLE;
                    error_d  = 1'b1;
                    shadow_d = '0;
                    idx_d    = '0;
                    xor_d    = '0;
                    tmo_d    = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            PENDING: begin
                if (!capture_busy) begin
                    setting_d = shadow_q[74:0];
                    update_d  = 1'b1;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            shadow_q        <= '0;
            idx_q           <= '0;
            xor_q           <= '0;
            tmo_q           <= '0;
            trigger_setting <= '0;
            setting_update  <= 1'b0;
            cfg_error       <= 1'b0;
        end else if (clk_enable) begin
            state_q         <= state_d;
            shadow_q        <= shadow_d;
            idx_q           <= idx_d;
            xor_q           <= xor_d;
            tmo_q           <= tmo_d;
            trigger_setting <= setting_d;
            setting_update  <= update_d;
            cfg_error       <= error_d;
        end
    end

endmodule

// File: tb/tb_hdlverifier_capture_trigger_config.sv
// Directed bench for the capture trigger configuration loader (TIMEOUT = 16).
module tb_hdlverifier_capture_trigger_config;

    localparam int TMO = 16;

    logic        clk;
    logic        reset;
    logic        clk_enable;
    logic [7:0]  cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        capture_busy;
    logic [74:0] trigger_setting;
    logic        setting_update;
    logic        cfg_error;

    localparam logic [79:0] PL_A  = {8'h03, 72'h0};
    localparam logic [74:0] EXP_A = {3'h3, 72'h0};
    localparam logic [79:0] PL_B  = {8'h05, 72'h998877665544332211};
    localparam logic [74:0] EXP_B = {3'h5, 72'h998877665544332211};
    localparam logic [79:0] PL_R  = {8'h83, 72'h0};

    int checks = 0;
    int errors = 0;
    int upd_rise = 0;
    int err_rise = 0;
    int both_hi = 0;
    logic upd_prev = 1'b0;
    logic err_prev = 1'b0;

    hdlverifier_capture_trigger_config #(.TIMEOUT(TMO)) dut (
        .clk             (clk),
        .reset           (reset),
        .clk_enable      (clk_enable),
        .cfg_data        (cfg_data),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .capture_busy    (capture_busy),
        .trigger_setting (trigger_setting),
        .setting_update  (setting_update),
        .cfg_error       (cfg_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (setting_update && !upd_prev) upd_rise <= upd_rise + 1;
        if (cfg_error && !err_prev) err_rise <= err_rise + 1;
        if (setting_update && cfg_error) both_hi <= both_hi + 1;
        upd_prev <= setting_update;
        err_prev <= cfg_error;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        cfg_data  = b;
        cfg_valid = 1'b1;
        if (gap) begin
            clk_enable = 1'b0;
            tick();
            clk_enable = 1'b1;
        end
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic send_packet(input logic [79:0] pl, input logic [7:0] ck, input bit gap);
        send_byte(8'hA5, gap);
        for (int k = 0; k < 10; k++) send_byte(pl[8*k +: 8], gap);
        send_byte(ck, gap);
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        clk_enable   = 1'b1;
        cfg_valid    = 1'b0;
        cfg_data     = 8'h00;
        capture_busy = 1'b0;
        tick();
        tick();
        checks++; if (trigger_setting !== 75'h0) begin errors++; $display("FAIL reset_trigger: got %0h expected 0", trigger_setting); end
        checks++; if (setting_update !== 1'b0) begin errors++; $display("FAIL reset_update: got %b expected 0", setting_update); end
        checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", cfg_error); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", cfg_ready); end
        reset = 1'b0;
        #1;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", cfg_ready); end
        tick();
    endtask

    task automatic test_valid_packet();
        int u0;
        int e0;
        u0 = upd_rise;
        e0 = err_rise;
        send_packet(PL_A, 8'h03, 1'b0);
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL valid_pending_ready: got %b expected 0", cfg_ready); end
        checks++; if (setting_update !== 1'b0) begin errors++; $display("FAIL valid_early_update: got %b expected 0", setting_update); end
        checks++; if (trigger_setting !== 75'h0) begin errors++; $display("FAIL valid_early_trigger: got %0h expected 0", trigger_setting); end
        tick();
        checks++; if (setting_update !== 1'b1) begin errors++; $display("FAIL valid_update: got %b expected 1", setting_update); end
        checks++; if (trigger_setting !== EXP_A) begin errors++; $display("FAIL valid_trigger: got %0h expected %0h", trigger_setting, EXP_A); end
        tick();
        checks++; if (setting_update !== 1'b0) begin errors++; $display("FAIL valid_update_width: got %b expected 0", setting_update); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL valid_back_idle: got %b expected 1", cfg_ready); end
        checks++; if (upd_rise - u0 !== 1) begin errors++; $display("FAIL valid_update_count: got %0d expected 1", upd_rise - u0); end
        checks++; if (err_rise - e0 !== 0) begin errors++; $display("FAIL valid_error_count: got %0d expected 0", err_rise - e0); end
    endtask

    task automatic test_bad_checksum();
        int u0;
        int e0;
        u0 = upd_rise;
        e0 = err_rise;
        send_packet(PL_A, 8'h02, 1'b0);
        checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL badck_error: got %b expected 1", cfg_error); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL badck_idle: got %b expected 1", cfg_ready); end
        tick();
        checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL badck_error_width: got %b expected 0", cfg_error); end
        checks++; if (trigger_setting !== EXP_A) begin errors++; $display("FAIL badck_trigger_kept: got %0h expected %0h", trigger_setting, EXP_A); end
        send_packet(PL_B, 8'h14, 1'b0);
        tick();
        checks++; if (setting_update !== 1'b1) begin errors++; $display("FAIL badck_next_update: got %b expected 1", setting_update); end
        checks++; if (trigger_setting !== EXP_B) begin errors++; $display("FAIL badck_next_trigger: got %0h expected %0h", trigger_setting, EXP_B); end
        tick();
        checks++; if (upd_rise - u0 !== 1) begin errors++; $display("FAIL badck_update_count: got %0d expected 1", upd_rise - u0); end
        checks++; if (err_rise - e0 !== 1) begin errors++; $display("FAIL badck_error_count: got %0d expected 1", err_rise - e0); end
    endtask

    task automatic test_reserved_bits();
        int u0;
        int e0;
        u0 = upd_rise;
        e0 = err_rise;
        send_packet(PL_R, 8'h83, 1'b0);
        checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL rsvd_error: got %b expected 1", cfg_error); end
        repeat (4) tick();
        checks++; if (trigger_setting !== EXP_B) begin errors++; $display("FAIL rsvd_trigger_kept: got %0h expected %0h", trigger_setting, EXP_B); end
        checks++; if (upd_rise - u0 !== 0) begin errors++; $display("FAIL rsvd_update_count: got %0d expected 0", upd_rise - u0); end
        checks++; if (err_rise - e0 !== 1) begin errors++; $display("FAIL rsvd_error_count: got %0d expected 1", err_rise - e0); end
    endtask

    task automatic test_busy_hold();
        int u0;
        int e0;
        int bad;
        u0 = upd_rise;
        e0 = err_rise;
        bad = 0;
        capture_busy = 1'b1;
        send_packet(PL_A, 8'h03, 1'b0);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (cfg_ready !== 1'b0 || setting_update !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL busy_hold_cycles: got %0d bad cycles expected 0", bad); end
        checks++; if (trigger_setting !== EXP_B) begin errors++; $display("FAIL busy_trigger_kept: got %0h expected %0h", trigger_setting, EXP_B); end
        capture_busy = 1'b0;
        tick();
        checks++; if (setting_update !== 1'b1) begin errors++; $display("FAIL busy_release_update: got %b expected 1", setting_update); end
        checks++; if (trigger_setting !== EXP_A) begin errors++; $display("FAIL busy_release_trigger: got %0h expected %0h", trigger_setting, EXP_A); end
        tick();
        checks++; if (upd_rise - u0 !== 1) begin errors++; $display("FAIL busy_update_count: got %0d expected 1", upd_rise - u0); end
        checks++; if (err_rise - e0 !== 0) begin errors++; $display("FAIL busy_error_count: got %0d expected 0", err_rise - e0); end
    endtask

    task automatic test_timeout();
        int e0;
        int early;
        e0 = err_rise;
        early = 0;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        for (int i = 1; i < TMO; i++) begin
            tick();
            if (cfg_error !== 1'b0) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL tmo_early_error: got %0d early cycles expected 0", early); end
        tick();
        checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL tmo_error: got %b expected 1", cfg_error); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL tmo_idle: got %b expected 1", cfg_ready); end
        tick();
        send_byte(8'h11, 1'b0);
        repeat (20) tick();
        checks++; if (err_rise - e0 !== 1) begin errors++; $display("FAIL tmo_error_count: got %0d expected 1", err_rise - e0); end
        checks++; if (trigger_setting !== EXP_A) begin errors++; $display("FAIL tmo_trigger_kept: got %0h expected %0h", trigger_setting, EXP_A); end
        send_packet(PL_B, 8'h14, 1'b0);
        tick();
        checks++; if (setting_update !== 1'b1) begin errors++; $display("FAIL tmo_next_update: got %b expected 1", setting_update); end
        checks++; if (trigger_setting !== EXP_B) begin errors++; $display("FAIL tmo_next_trigger: got %0h expected %0h", trigger_setting, EXP_B); end
        tick();
    endtask

    task automatic test_enable_gaps();
        int u0;
        int e0;
        u0 = upd_rise;
        e0 = err_rise;
        send_packet(PL_A, 8'h03, 1'b1);
        clk_enable = 1'b0;
        #1;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL gap_ready_disabled: got %b expected 0", cfg_ready); end
        tick();
        checks++; if (setting_update !== 1'b0) begin errors++; $display("FAIL gap_update_held: got %b expected 0", setting_update); end
        checks++; if (trigger_setting !== EXP_B) begin errors++; $display("FAIL gap_trigger_held: got %0h expected %0h", trigger_setting, EXP_B); end
        clk_enable = 1'b1;
        tick();
        checks++; if (setting_update !== 1'b1) begin errors++; $display("FAIL gap_update: got %b expected 1", setting_update); end
        checks++; if (trigger_setting !== EXP_A) begin errors++; $display("FAIL gap_trigger: got %0h expected %0h", trigger_setting, EXP_A); end
        clk_enable = 1'b0;
        tick();
        clk_enable = 1'b1;
        tick();
        checks++; if (setting_update !== 1'b0) begin errors++; $display("FAIL gap_update_clear: got %b expected 0", setting_update); end
        tick();
        checks++; if (upd_rise - u0 !== 1) begin errors++; $display("FAIL gap_update_count: got %0d expected 1", upd_rise - u0); end
        checks++; if (err_rise - e0 !== 0) begin errors++; $display("FAIL gap_error_count: got %0d expected 0", err_rise - e0); end
    endtask

    task automatic test_reset_mid_packet();
        int u0;
        int e0;
        u0 = upd_rise;
        e0 = err_rise;
        send_byte(8'hA5, 1'b0);
        for (int k = 0; k < 6; k++) send_byte(PL_B[8*k +: 8], 1'b0);
        reset = 1'b1;
        #1;
        checks++; if (trigger_setting !== 75'h0) begin errors++; $display("FAIL midrst_trigger: got %0h expected 0", trigger_setting); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", cfg_ready); end
        checks++; if (setting_update !== 1'b0 || cfg_error !== 1'b0) begin errors++; $display("FAIL midrst_pulses: got %b%b expected 00", setting_update, cfg_error); end
        tick();
        tick();
        reset = 1'b0;
        repeat (20) tick();
        checks++; if (upd_rise - u0 !== 0) begin errors++; $display("FAIL midrst_update_count: got %0d expected 0", upd_rise - u0); end
        checks++; if (err_rise - e0 !== 0) begin errors++; $display("FAIL midrst_error_count: got %0d expected 0", err_rise - e0); end
        checks++; if (trigger_setting !== 75'h0) begin errors++; $display("FAIL midrst_trigger_after: got %0h expected 0", trigger_setting); end
        send_packet(PL_A, 8'h03, 1'b0);
        tick();
        checks++; if (setting_update !== 1'b1) begin errors++; $display("FAIL midrst_next_update: got %b expected 1", setting_update); end
        checks++; if (trigger_setting !== EXP_A) begin errors++; $display("FAIL midrst_next_trigger: got %0h expected %0h", trigger_setting, EXP_A); end
        tick();
    endtask

    initial begin
        test_reset();
        test_valid_packet();
        test_bad_checksum();
        test_reserved_bits();
        test_busy_hold();
        test_timeout();
        test_enable_gaps();
        test_reset_mid_packet();
        tick();
        checks++; if (both_hi !== 0) begin errors++; $display("FAIL exclusive_pulses: got %0d overlapping cycles expected 0", both_hi); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
